// File: rtl/div36x18_pkg.sv
// Shared widths, FSM encoding and saturation constants for the 36/18 signed divider.
package div36x18_pkg;

  localparam int unsigned PW = 36;
  localparam int unsigned DW = 18;
  localparam int unsigned QW = 18;
  localparam int unsigned CW = 6;

  localparam logic [QW-1:0] QMAX = 18'h1FFFF;
  localparam logic [QW-1:0] QMIN = 18'h20000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  // Magnitudes as unsigned values; -2^(W-1) maps onto 2^(W-1) without loss.
  function automatic logic [PW-1:0] abs_p(input logic [PW-1:0] v);
    return v[PW-1] ? (PW'(0) - v) : v;
  endfunction

  function automatic logic [DW-1:0] abs_d(input logic [DW-1:0] v);
    return v[DW-1] ? (DW'(0) - v) : v;
  endfunction

endpackage

// File: rtl/x_div36x18sio_if.sv
// Request/result bundle of the 36/18 signed divider; master drives operands, slave returns results.
interface x_div36x18sio_if;

  logic                          CE;
  logic                          START;
  logic [div36x18_pkg::PW-1:0]   P;
  logic [div36x18_pkg::DW-1:0]   D;
  logic [div36x18_pkg::QW-1:0]   Q;
  logic [div36x18_pkg::QW-1:0]   R;
  logic                          BUSY;
  logic                          DONE;
  logic                          DIV0;
  logic                          OVF;

  modport master (
    output CE, START, P, D,
    input  Q, R, BUSY, DONE, DIV0, OVF
  );

  modport slave (
    input  CE, START, P, D,
    output Q, R, BUSY, DONE, DIV0, OVF
  );

endinterface

// File: rtl/div36x18_step.sv
// One restoring-division iteration: shift the remainder/dividend pair, trial-subtract, select.
module div36x18_step
  import div36x18_pkg::*;
(
  input  logic [DW-1:0] rem_i,
  input  logic [PW-1:0] dvd_i,
  input  logic [DW-1:0] dm_i,
  output logic [DW-1:0] rem_c_o,
  output logic [PW-1:0] dvd_c_o
);

  logic [DW:0] sh_c;
  logic [DW:0] diff_c;
  logic        ge_c;

  // Remainder stays below |D| <= 2^17, so 19 bits hold the shifted value and the trial sign.
  always_comb begin
    sh_c    = {rem_i, dvd_i[PW-1]};
    diff_c  = sh_c - {1'b0, dm_i};
    ge_c    = ~diff_c[DW];
    rem_c_o = ge_c ? diff_c[DW-1:0] : sh_c[DW-1:0];
    dvd_c_o = {dvd_i[PW-2:0], ge_c};
  end

endmodule

// File: rtl/x_div36x18sio.sv
// Fixed-latency (38 cycle) signed 36/18 restoring divider with START/BUSY/DONE handshake.
// Build option: DIV36X18_SAT_EN saturates Q on overflow instead of wrapping.
module x_div36x18sio
  import div36x18_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  x_div36x18sio_if.slave   bus
);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   dvd_q, dvd_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   dm_q, dm_d;
  logic            sp_q, sp_d;
  logic            sq_q, sq_d;
  logic            z_q, z_d;
  logic [QW-1:0]   q_q, q_d;
  logic [QW-1:0]   r_q, r_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;

  logic [DW-1:0]   step_rem_c;
  logic [PW-1:0]   step_dvd_c;
  logic [QW-1:0]   qwrap_c;
  logic [QW-1:0]   qsel_c;
  logic            ovf_c;
  logic [QW-1:0]   qres_c;
  logic [QW-1:0]   rres_c;
  logic            ovfres_c;

  div36x18_step u_step (
    .rem_i   (rem_q),
    .dvd_i   (dvd_q),
    .dm_i    (dm_q),
    .rem_c_o (step_rem_c),
    .dvd_c_o (step_dvd_c)
  );

  // Sign fix-up, overflow detection and divide-by-zero override of the magnitude result.
  always_comb begin
    qwrap_c = sq_q ? (QW'(0) - dvd_q[QW-1:0]) : dvd_q[QW-1:0];
    ovf_c   = sq_q ? ((|dvd_q[PW-1:QW]) | (dvd_q[QW-1] & (|dvd_q[QW-2:0])))
                   : (|dvd_q[PW-1:QW-1]);
`ifdef DIV36X18_SAT_EN
    qsel_c  = ovf_c ? (sq_q ? QMIN : QMAX) : qwrap_c;
`else
    qsel_c  = qwrap_c;
`endif
    if (z_q) begin
      qres_c   = sp_q ? QMIN : QMAX;
      rres_c   = '0;
      ovfres_c = 1'b0;
    end else begin
      qres_c   = qsel_c;
      rres_c   = sp_q ? (DW'(0) - rem_q) : rem_q;
      ovfres_c = ovf_c;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dm_d    = dm_q;
    sp_d    = sp_q;
    sq_d    = sq_q;
    z_d     = z_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = div0_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          dvd_d   = abs_p(bus.P);
          rem_d   = '0;
          dm_d    = abs_d(bus.D);
          sp_d    = bus.P[PW-1];
          sq_d    = bus.P[PW-1] ^ bus.D[DW-1];
          z_d     = (bus.D == '0);
          cnt_d   = CW'(PW - 1);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        dvd_d = step_dvd_c;
        rem_d = step_rem_c;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        q_d     = qres_c;
        r_d     = rres_c;
        div0_d  = z_q;
        ovf_d   = ovfres_c;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset wins over CE; CE low freezes every register including DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dm_q    <= '0;
      sp_q    <= 1'b0;
      sq_q    <= 1'b0;
      z_q     <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.CE) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dm_q    <= dm_d;
      sp_q    <= sp_d;
      sq_q    <= sq_d;
      z_q     <= z_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.DIV0 = div0_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_x_div36x18sio.sv
// Directed bench for x_div36x18sio: scoreboard of modelled results popped on each DONE.
module tb_x_div36x18sio;
  import div36x18_pkg::*;

  typedef struct {
    logic [17:0] q;
    logic [17:0] r;
    logic        div0;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   nchk  = 0;
  int   npass = 0;
  int   nfail = 0;
  int   cyc   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  x_div36x18sio_if bus ();

  x_div36x18sio dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  function automatic exp_t model(input logic [35:0] p, input logic [17:0] d);
    exp_t   e;
    longint ps, ds, qt, rt;
    ps = longint'($signed(p));
    ds = longint'($signed(d));
    if (ds == 0) begin
      e.div0 = 1'b1;
      e.ovf  = 1'b0;
      e.r    = '0;
      e.q    = (ps < 0) ? 18'h20000 : 18'h1FFFF;
    end else begin
      qt     = ps / ds;
      rt     = ps % ds;
      e.div0 = 1'b0;
      e.ovf  = (qt > 131071) || (qt < -131072);
      e.q    = 18'(qt);
`ifdef DIV36X18_SAT_EN
      if (e.ovf) e.q = (qt > 0) ? 18'h1FFFF : 18'h20000;
`endif
      e.r    = 18'(rt);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; the rising edge in between samples START.
  task automatic launch(input logic [35:0] p, input logic [17:0] d, input bit hold);
    bus.START = 1'b1;
    bus.P     = p;
    bus.D     = d;
    sb.push_back(model(p, d));
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.START = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (1) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (bus.DONE === 1'b1) break;
      if (k >= 100) begin
        chk("done_timeout", 64'(bus.DONE), 64'(1));
        break;
      end
    end
  endtask

  task automatic check_done(input string tag, input int k, input int k_exp);
    exp_t e;
    chk({tag, "_edges"}, 64'(k), 64'(k_exp));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"},    64'(bus.Q),    64'(e.q));
      chk({tag, "_r"},    64'(bus.R),    64'(e.r));
      chk({tag, "_div0"}, 64'(bus.DIV0), 64'(e.div0));
      chk({tag, "_ovf"},  64'(bus.OVF),  64'(e.ovf));
      chk({tag, "_busy"}, 64'(bus.BUSY), 64'(0));
    end
  endtask

  task automatic run(input string tag, input logic [35:0] p, input logic [17:0] d);
    int k;
    launch(p, d, 1'b0);
    wait_done(k);
    check_done(tag, k, 37);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.DONE), 64'(0));
  endtask

  initial begin
    int          k;
    int          c1;
    int          dn;
    logic [35:0] rp;
    logic [17:0] rd;
    logic [17:0] rx;

    rst       = 1'b1;
    bus.CE    = 1'b1;
    bus.START = 1'b0;
    bus.P     = '0;
    bus.D     = '0;
    repeat (3) @(negedge clk);
    chk("rst_q",    64'(bus.Q),    64'(0));
    chk("rst_r",    64'(bus.R),    64'(0));
    chk("rst_busy", 64'(bus.BUSY), 64'(0));
    chk("rst_done", 64'(bus.DONE), 64'(0));
    chk("rst_div0", 64'(bus.DIV0), 64'(0));
    chk("rst_ovf",  64'(bus.OVF),  64'(0));
    rst = 1'b0;
    @(negedge clk);

    run("p100_d7", 36'd100, 18'd7);
    chk("p100_d7_lit", 64'(bus.Q), 64'(14));
    run("m100_d7", 36'(-100), 18'd7);
    chk("m100_d7_lit", 64'(bus.Q), 64'(18'h3FFF2));
    run("qmin", 36'(-131072), 18'd1);
    run("qmax_ovf", 36'd131072, 18'd1);
`ifdef DIV36X18_SAT_EN
    chk("qmax_ovf_lit", 64'(bus.Q), 64'(18'h1FFFF));
`else
    chk("qmax_ovf_lit", 64'(bus.Q), 64'(18'h20000));
`endif
    run("div0_pos", 36'd1000, 18'd0);
    run("div0_neg", 36'(-5), 18'd0);
    run("pmin_dmin", 36'h8_0000_0000, 18'h20000);
    run("p2e34_dmin", 36'h4_0000_0000, 18'h20000);
    run("pmin_d1", 36'h8_0000_0000, 18'd1);
    run("pmax_dm1", 36'h7_FFFF_FFFF, 18'h3FFFF);
    run("m7_d2", 36'(-7), 18'(-2));

    for (int i = 0; i < 3; i++) begin
      rp = 36'({$urandom(), $urandom()});
      rd = 18'($urandom());
      if (rd == '0) rd = 18'd3;
      run($sformatf("rnd_wide%0d", i), rp, rd);
      rx = 18'($urandom());
      rd = 18'($urandom_range(1, 300));
      run($sformatf("rnd_fit%0d", i), {{18{rx[17]}}, rx}, rd);
    end

    // START held high through both operations: back-to-back, 38 cycles apart.
    launch(36'd5000, 18'd9, 1'b1);
    wait_done(k);
    c1 = cyc;
    check_done("hold1", k, 37);
    bus.P = 36'(-77777);
    bus.D = 18'd123;
    sb.push_back(model(36'(-77777), 18'd123));
    wait_done(k);
    check_done("hold2", k, 38);
    chk("hold_period", 64'(cyc - c1), 64'(38));
    bus.START = 1'b0;
    @(negedge clk);

    // Five CE-low cycles in the middle of CALC.
    launch(36'd99999, 18'(-321), 1'b0);
    repeat (9) @(negedge clk);
    bus.CE = 1'b0;
    repeat (5) @(negedge clk);
    chk("ce_frz_busy", 64'(bus.BUSY), 64'(1));
    bus.CE = 1'b1;
    wait_done(k);
    check_done("ce_mid", k, 28);
    @(negedge clk);

    // CE low at completion keeps DONE asserted.
    launch(36'(-100), 18'd7, 1'b0);
    wait_done(k);
    check_done("ce_end", k, 37);
    bus.CE = 1'b0;
    repeat (3) @(negedge clk);
    chk("ce_end_hold", 64'(bus.DONE), 64'(1));
    bus.CE = 1'b1;
    @(negedge clk);
    chk("ce_end_clr", 64'(bus.DONE), 64'(0));

    // Reset partway through an operation aborts it.
    launch(36'd424242, 18'd17, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_q",    64'(bus.Q),    64'(0));
    chk("abort_r",    64'(bus.R),    64'(0));
    chk("abort_busy", 64'(bus.BUSY), 64'(0));
    chk("abort_done", 64'(bus.DONE), 64'(0));
    rst = 1'b0;
    void'(sb.pop_back());
    dn = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'(0));
    run("after_abort", 36'd424242, 18'd17);

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
